uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter: INTERBYTE_TO, default 1_000_000, cycles allowed between bytes of one frame (10 ms at 100 MHz).
REQ-002 Parameter: HOLD_TO, default 20_000_000, cycles a player's keys are held without a fresh good frame (200 ms).
REQ-003 Port: clk  in  1  100 MHz system clock; the block has one clock; all flops on posedge clk.
REQ-004 Port: rstn  in  1  asynchronous active-low reset.
REQ-005 Port: rx_data  in  8  byte from the UART receiver.
REQ-006 Port: rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-007 Port: p0_keys  out  5  player 0 keys: bit0 up, bit1 down, bit2 left, bit3 right, bit4 fire.
REQ-008 Port: p1_keys  out  5  player 1 keys, same bit map as p0_keys.
REQ-009 Port: frame_ok  out  1  one-cycle pulse per accepted frame.
REQ-010 Port: frame_err  out  1  one-cycle pulse per rejected frame or inter-byte timeout.
REQ-011 Port: err_cnt  out  8  saturating count of frame_err pulses.

Function
REQ-012 Frame is 4 bytes: 0xAA header, ID (0x00 or 0x01), KEYS (bits 7:5 must be 0), SUM = ID XOR KEYS.
REQ-013 FSM states are S_HDR, S_ID, S_KEY, S_SUM; the FSM advances only in cycles where rx_valid=1.
REQ-014 S_HDR: byte 0xAA goes to S_ID; any other byte is discarded silently, with no frame_err.
REQ-015 S_ID: byte 0x00 or 0x01 is latched and goes to S_KEY; any other byte pulses frame_err and goes to S_HDR.
REQ-016 S_KEY: the byte is latched and goes to S_SUM; KEYS bits 7:5 are checked in S_SUM.
REQ-017 S_SUM is accepted only if byte == ID^KEYS and KEYS[7:5]==0.
REQ-018 On acceptance, the selected pN_keys <= KEYS[4:0] and frame_ok pulses in the cycle after the SUM rx_valid (latency 1); the FSM goes to S_HDR.
REQ-019 On rejection, frame_err pulses with latency 1; the FSM goes to S_ID if the rejected byte is 0xAA (resync), otherwise to S_HDR.
REQ-020 Inter-byte counter: cleared on every rx_valid; in S_ID, S_KEY or S_SUM, reaching INTERBYTE_TO-1 with no byte pulses frame_err once and forces S_HDR.
REQ-021 The inter-byte counter is held at 0 in S_HDR.
REQ-022 One hold counter per player: reloaded on that player's accepted frame.
REQ-023 On hold-counter expiry (HOLD_TO-1 reached), that player's keys are cleared to 0 and the counter stops until the next accepted frame.
REQ-024 If an accepted frame and hold expiry for the same player fall in one cycle, the frame wins: keys take the new value and the timer reloads.
REQ-025 err_cnt increments by 1 per frame_err and saturates at 255.
REQ-026 frame_ok and frame_err never both assert in one cycle.
REQ-027 rx_valid is never back-to-back in practice, but the block accepts one byte per cycle regardless.
REQ-028 A frame for one player never modifies the other player's keys or hold timer.

Reset
REQ-029 Asserting rstn=0 at any time, including mid-frame, forces: S_HDR, all counters 0, hold timers stopped, all outputs 0.
REQ-030 A partial frame in progress at reset is discarded, with no pulse after reset release.
REQ-031 The first byte after reset release is parsed as a candidate header.

Structure
REQ-032 A shared input package holds: the header constant 0xAA, key bit indices (UP=0, DOWN=1, LEFT=2, RIGHT=3, FIRE=4), the FSM state encoding and the player ID constants.
REQ-033 One sub-module, key_hold_timer, is instantiated twice (one per player).
REQ-034 key_hold_timer ports: load strobe, 5-bit key in, 5-bit key out, HOLD_TO parameter.

Verification
REQ-035 Scenario (accept): bytes AA 00 11 11 -> next cycle p0_keys=5'h11 and frame_ok=1 for one cycle; p1_keys stays 0.
REQ-036 Scenario (bad checksum with resync): AA 01 05 AA then 01 05 04 -> first frame_err=1 and err_cnt=1; then p1_keys=5'h05 with no extra header needed.
REQ-037 Scenario (inter-byte timeout): AA 00 then silence for INTERBYTE_TO cycles -> single frame_err pulse; a following AA 00 03 03 is accepted.
REQ-038 Scenario (hold timeout): accepted frame p0=0x10, then no frames for HOLD_TO cycles -> p0_keys=0 exactly HOLD_TO cycles after the update.
REQ-039 Scenario (timer collision): frame timed to land on the expiry cycle -> keys take the new value and are not cleared.
REQ-040 Scenario (reset mid-frame): rstn pulsed low after AA 00 -> all outputs 0; subsequent 00 11 bytes produce no frame_ok.
REQ-041 Scenario (saturation): 300 frames with bad ID (AA 07) -> err_cnt=255.

Source files
------------

// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants and types for the UART command parser: frame bytes,
// key bit positions, player IDs and the frame FSM encoding.
package uart_cmd_parser_pkg;
  localparam logic [7:0] HDR_BYTE = 8'hAA;
  localparam logic [7:0] PID_0    = 8'h00;
  localparam logic [7:0] PID_1    = 8'h01;
  localparam int KEY_W     = 5;
  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_FIRE  = 4;

  typedef enum logic [1:0] {S_HDR, S_ID, S_KEY, S_SUM} state_e;
endpackage

// File: rtl/uart_cmd_parser_key_hold_timer.sv
// Per-player key register; keys drop to 0 after HOLD_TO cycles without a fresh
// load. A load in the expiry cycle takes priority and restarts the timer.
module key_hold_timer
  import uart_cmd_parser_pkg::*;
#(
  parameter int HOLD_TO = 20_000_000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_out
);
  localparam int CW = (HOLD_TO > 1) ? $clog2(HOLD_TO) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_TO - 1);

  logic [CW-1:0] cnt;
  logic          run;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_out <= '0;
      cnt     <= '0;
      run     <= 1'b0;
    end else if (load) begin
      key_out <= key_in;
      cnt     <= '0;
      run     <= 1'b1;
    end else if (run) begin
      if (cnt == LAST) begin
        key_out <= '0;
        run     <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_cmd_parser.sv
// Parses 4-byte AA/ID/KEYS/SUM frames from a UART byte stream into two
// players' held key states, with inter-byte timeout and error counting.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int INTERBYTE_TO = 1_000_000,
  parameter int HOLD_TO      = 20_000_000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [KEY_W-1:0] p0_keys,
  output logic [KEY_W-1:0] p1_keys,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [7:0]       err_cnt
);
  localparam int IBW = (INTERBYTE_TO > 1) ? $clog2(INTERBYTE_TO) : 1;
  localparam logic [IBW-1:0] IB_LAST = IBW'(INTERBYTE_TO - 1);

  state_e         state, state_nx;
  logic [7:0]     id_q, key_q;
  logic [IBW-1:0] ib_cnt;
  logic           ib_to;
  logic           ok_d, err_d, ld_id, ld_key, load0, load1;

  assign ib_to = (state != S_HDR) && !rx_valid && (ib_cnt == IB_LAST);

  always_comb begin
    state_nx = state;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    ld_id    = 1'b0;
    ld_key   = 1'b0;
    load0    = 1'b0;
    load1    = 1'b0;
    if (rx_valid) begin
      case (state)
        S_HDR: if (rx_data == HDR_BYTE) state_nx = S_ID;
        S_ID: begin
          if (rx_data == PID_0 || rx_data == PID_1) begin
            ld_id    = 1'b1;
            state_nx = S_KEY;
          end else begin
            err_d    = 1'b1;
            state_nx = S_HDR;
          end
        end
        S_KEY: begin
          ld_key   = 1'b1;
          state_nx = S_SUM;
        end
        S_SUM: begin
          if (rx_data == (id_q ^ key_q) && key_q[7:5] == 3'b000) begin
            ok_d     = 1'b1;
            load0    = (id_q == PID_0);
            load1    = (id_q == PID_1);
            state_nx = S_HDR;
          end else begin
            // a rejected SUM that looks like a header starts the next frame
            err_d    = 1'b1;
            state_nx = (rx_data == HDR_BYTE) ? S_ID : S_HDR;
          end
        end
        default: state_nx = S_HDR;
      endcase
    end else if (ib_to) begin
      err_d    = 1'b1;
      state_nx = S_HDR;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_HDR;
      id_q      <= '0;
      key_q     <= '0;
      ib_cnt    <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nx;
      frame_ok  <= ok_d;
      frame_err <= err_d;
      if (ld_id)  id_q  <= rx_data;
      if (ld_key) key_q <= rx_data;
      if (rx_valid || state == S_HDR || ib_to) ib_cnt <= '0;
      else                                      ib_cnt <= ib_cnt + 1'b1;
      if (err_d && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end
  end

  key_hold_timer #(.HOLD_TO(HOLD_TO)) u_hold0 (
    .clk(clk), .rstn(rstn), .load(load0), .key_in(key_q[KEY_W-1:0]), .key_out(p0_keys)
  );

  key_hold_timer #(.HOLD_TO(HOLD_TO)) u_hold1 (
    .clk(clk), .rstn(rstn), .load(load1), .key_in(key_q[KEY_W-1:0]), .key_out(p1_keys)
  );
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with shortened timeouts.
module tb_uart_cmd_parser;
  localparam int IB   = 16;
  localparam int HOLD = 64;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] p0_keys, p1_keys;
  logic       frame_ok, frame_err;
  logic [7:0] err_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  uart_cmd_parser #(.INTERBYTE_TO(IB), .HOLD_TO(HOLD)) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .p0_keys(p0_keys), .p1_keys(p1_keys), .frame_ok(frame_ok),
    .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one byte for one cycle; returns at the negedge after it was captured
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send4(input logic [7:0] b0, b1, b2, b3);
    send(b0); send(b1); send(b2); send(b3);
  endtask

  initial begin
    int errs;
    rstn = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_p0", 32'(p0_keys), 0);
    chk("rst_p1", 32'(p1_keys), 0);
    chk("rst_ok", 32'(frame_ok), 0);
    chk("rst_err", 32'(frame_err), 0);
    chk("rst_cnt", 32'(err_cnt), 0);
    rstn = 1'b1;

    // accept for player 0
    send4(8'hAA, 8'h00, 8'h11, 8'h11);
    chk("acc_ok", 32'(frame_ok), 1);
    chk("acc_err", 32'(frame_err), 0);
    chk("acc_p0", 32'(p0_keys), 32'h11);
    chk("acc_p1", 32'(p1_keys), 0);
    @(negedge clk);
    chk("acc_ok_pulse", 32'(frame_ok), 0);

    // bad checksum, AA resyncs straight into a player-1 frame
    send4(8'hAA, 8'h01, 8'h05, 8'hAA);
    chk("bad_err", 32'(frame_err), 1);
    chk("bad_ok", 32'(frame_ok), 0);
    chk("bad_cnt", 32'(err_cnt), 1);
    send(8'h01); send(8'h05); send(8'h04);
    chk("resync_ok", 32'(frame_ok), 1);
    chk("resync_p1", 32'(p1_keys), 32'h05);
    chk("resync_p0", 32'(p0_keys), 32'h11);

    // inter-byte timeout
    send(8'hAA); send(8'h00);
    errs = 0;
    for (int i = 0; i < 2*IB; i++) begin
      @(negedge clk);
      if (frame_err) errs++;
    end
    chk("ib_pulses", 32'(errs), 1);
    chk("ib_cnt", 32'(err_cnt), 2);
    send4(8'hAA, 8'h00, 8'h03, 8'h03);
    chk("ib_after_ok", 32'(frame_ok), 1);
    chk("ib_after_p0", 32'(p0_keys), 32'h03);

    // hold timeout: keys clear exactly HOLD cycles after the update edge
    send4(8'hAA, 8'h00, 8'h10, 8'h10);
    chk("hold_set", 32'(p0_keys), 32'h10);
    repeat (HOLD-1) @(negedge clk);
    chk("hold_before", 32'(p0_keys), 32'h10);
    @(negedge clk);
    chk("hold_clear", 32'(p0_keys), 0);

    // collision: SUM captured on the expiry edge (update edge + HOLD)
    send4(8'hAA, 8'h00, 8'h10, 8'h10);
    repeat (HOLD-8) @(negedge clk);
    send(8'hAA); send(8'h00); send(8'h05);
    chk("coll_before", 32'(p0_keys), 32'h10);
    send(8'h05);
    chk("coll_ok", 32'(frame_ok), 1);
    chk("coll_p0", 32'(p0_keys), 32'h05);
    repeat (HOLD-1) @(negedge clk);
    chk("coll_reload", 32'(p0_keys), 32'h05);

    // reset mid-frame
    send(8'hAA); send(8'h00);
    rstn = 1'b0;
    #1;
    chk("mid_rst_p0", 32'(p0_keys), 0);
    chk("mid_rst_p1", 32'(p1_keys), 0);
    chk("mid_rst_cnt", 32'(err_cnt), 0);
    @(negedge clk);
    rstn = 1'b1;
    errs = 0;
    send(8'h00); if (frame_ok || frame_err) errs++;
    send(8'h11); if (frame_ok || frame_err) errs++;
    send(8'h11); if (frame_ok || frame_err) errs++;
    chk("mid_rst_silent", 32'(errs), 0);
    chk("mid_rst_p0b", 32'(p0_keys), 0);

    // checksum good but KEYS[7:5] nonzero
    send4(8'hAA, 8'h00, 8'h25, 8'h25);
    chk("hibits_err", 32'(frame_err), 1);
    chk("hibits_ok", 32'(frame_ok), 0);
    chk("hibits_p0", 32'(p0_keys), 0);
    chk("hibits_cnt", 32'(err_cnt), 1);

    // saturation with bad IDs
    for (int i = 0; i < 300; i++) begin
      send(8'hAA); send(8'h07);
    end
    chk("sat_err", 32'(frame_err), 1);
    chk("sat_ok", 32'(frame_ok), 0);
    chk("sat_cnt", 32'(err_cnt), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
